riscv_regfile: RTL and testbench
================================

Name: riscv_regfile

Overview:
- 32 x 32-bit integer register file (x0..x31) for the single-cycle RV32I datapath.
- Directly upstream of the ALU operand-B select mux: rs2_data drives the mux "a" input, and rs1_data feeds ALU operand A.
- Two combinational read ports and one synchronous write port, fed from the writeback-select mux.
- Includes a debug read port for the testbench and register dumps.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers. Fixed at 32; address width is log2(NREGS)=5.
- RESET_VAL, 32'h0000_0000, value loaded into x1..x31 on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low; clears all registers.
- rs1_addr  in  5  read port 1 address.
- rs2_addr  in  5  read port 2 address.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational; to the operand-B mux "a" input.
- we  in  1  write enable, sampled at rising clk.
- rd_addr  in  5  write address.
- rd_data  in  XLEN  write data, from writeback mux.
- dbg_addr  in  5  debug read address.
- dbg_data  out  XLEN  debug read data, combinational.
- wr_count  out  16  count of committed writes to x1..x31, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset entry: while rst_n=0, all of x1..x31 = RESET_VAL and wr_count = 0, immediately and without a clock edge.
- Reset exit: first write can commit on the first rising clk after rst_n deasserts.
- Reset during a write: if rst_n is asserted in the same cycle as a write, reset wins and the write is lost.
- Reset-time outputs: read outputs are combinational, so during reset rs1_data, rs2_data and dbg_data show RESET_VAL, or 0 for address 0.
- x0: reads always return 0. A write with rd_addr=0 is discarded and does not increment wr_count.
- Write: at a rising clk with rst_n=1, we=1 and rd_addr!=0, reg[rd_addr] <= rd_data. The value is visible on the read ports after the edge (latency 1 clock).
- we=0: no state change.
- Reads: pure combinational index of the register array.
- Same-cycle read and write to the same address without bypass: the read returns the OLD value; the new value appears after the edge.
- Both read ports may address the same register simultaneously; no restriction.
- wr_count increments by 1 on each committed write (we=1, rd_addr!=0).
- wr_count saturates at 16'hFFFF and holds there; it does not wrap.
- No X propagation: every register has a defined reset value. Undefined addresses are impossible since 5 bits cover all 32 registers.
- Implementation: no latches; the array is built from flops with asynchronous clear.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: if we=1, rd_addr!=0 and rsN_addr==rd_addr, then rsN_data = rd_data combinationally in the same cycle.
  - Applies to rs1, rs2 and dbg independently.
  - x0 is never bypassed.
  - Forwarding is gated with rst_n: no forwarding while rst_n=0.
- Undefined: no forwarding; reads return stored contents only, as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0, pulse clk with we=1, rd_addr=5, rd_data=32'hDEAD_BEEF, then release -> dbg_addr=5 reads 0, wr_count=0.
- Basic write/read: we=1, rd_addr=3, rd_data=32'h1234_5678; next cycle rs1_addr=3, rs2_addr=3 -> both read 32'h1234_5678, wr_count=1.
- x0 protection: we=1, rd_addr=0, rd_data=32'hFFFF_FFFF -> rs1_addr=0 reads 0, wr_count unchanged.
- Same-cycle collision: x7=32'hA; in one cycle we=1, rd_addr=7, rd_data=32'hB, rs2_addr=7 -> rs2_data reads 32'hA without macro and 32'hB with REGFILE_BYPASS_EN; after the edge both builds read 32'hB.
- Async reset mid-operation: x9=32'h55 written; drop rst_n between clock edges -> x9 reads 0 immediately, before the next clk edge; a write presented in that cycle is lost.
- Counter saturation: force 65540 writes to x1 -> wr_count=16'hFFFF and holds; last data written is readable.

Source files
------------

// File: rtl/riscv_regfile_if.sv
// riscv_regfile_if: read/write/debug port bundle for the RV32I integer register file
interface riscv_regfile_if #(
   parameter int XLEN = 32
);
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            we;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic [4:0]      dbg_addr;
   logic [XLEN-1:0] dbg_data;
   logic [15:0]     wr_count;

   modport master (
      output rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
      input  rs1_data, rs2_data, dbg_data, wr_count
   );

   modport slave (
      input  rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
      output rs1_data, rs2_data, dbg_data, wr_count
   );
endinterface

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 RV32I register file, 2 comb read + 1 sync write + debug read, saturating write counter; REGFILE_BYPASS_EN adds write-through forwarding
module riscv_regfile #(
   parameter int              XLEN      = 32,
   parameter int              NREGS     = 32,
   parameter logic [XLEN-1:0] RESET_VAL = '0
) (
   input logic              clk,
   input logic              rst_n,
   riscv_regfile_if.slave   rf
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [15:0]     cnt_q;
   logic [15:0]     cnt_d;
   logic            wr_en;

   // x0 writes are discarded entirely, so they neither store nor count
   assign wr_en = rf.we && (rf.rd_addr != '0);

   // next state: one register updated, counter stepped until it pins at all-ones
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[rf.rd_addr[AW-1:0]] = rf.rd_data;
      cnt_d = (wr_en && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   end

   // state registers with async clear; entry 0 is held at zero so reads of x0 need no special case
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
         cnt_q <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign rf.rs1_data = (rst_n && wr_en && rf.rs1_addr == rf.rd_addr) ? rf.rd_data : regs_q[rf.rs1_addr[AW-1:0]];
   assign rf.rs2_data = (rst_n && wr_en && rf.rs2_addr == rf.rd_addr) ? rf.rd_data : regs_q[rf.rs2_addr[AW-1:0]];
   assign rf.dbg_data = (rst_n && wr_en && rf.dbg_addr == rf.rd_addr) ? rf.rd_data : regs_q[rf.dbg_addr[AW-1:0]];
`else
   assign rf.rs1_data = regs_q[rf.rs1_addr[AW-1:0]];
   assign rf.rs2_data = regs_q[rf.rs2_addr[AW-1:0]];
   assign rf.dbg_data = regs_q[rf.dbg_addr[AW-1:0]];
`endif

   assign rf.wr_count = cnt_q;
endmodule

// File: tb/tb_riscv_regfile.sv
// tb_riscv_regfile: directed scoreboard bench for riscv_regfile
module tb_riscv_regfile;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [31:0] exp_val [$];
   string       exp_tag [$];

   riscv_regfile_if #(.XLEN(32)) rf ();

   riscv_regfile #(.XLEN(32), .NREGS(32), .RESET_VAL(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_tag.push_back(tag);
      exp_val.push_back(v);
   endtask

   task automatic check(input logic [31:0] obs);
      string       tag;
      logic [31:0] e;
      checks++;
      if (exp_val.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed %h expected none", obs);
      end else begin
         tag = exp_tag.pop_front();
         e   = exp_val.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      rf.we = 1'b1; rf.rd_addr = a; rf.rd_data = d;
      @(posedge clk);
      #1 rf.we = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      rf.rs1_addr = '0; rf.rs2_addr = '0; rf.dbg_addr = 5'd5;
      rf.we = 1'b1; rf.rd_addr = 5'd5; rf.rd_data = 32'hDEAD_BEEF;
      expect_val("rst_dbg5", 32'h0);
      expect_val("rst_cnt", 32'h0);
      #1;
      check(rf.dbg_data);
      check({16'h0, rf.wr_count});
      repeat (2) @(posedge clk);
      expect_val("rst_pulse_dbg5", 32'h0);
      expect_val("rst_pulse_cnt", 32'h0);
      #1;
      check(rf.dbg_data);
      check({16'h0, rf.wr_count});
      @(negedge clk);
      rf.we = 1'b0; rst_n = 1'b1;
      expect_val("rel_dbg5", 32'h0);
      expect_val("rel_cnt", 32'h0);
      #1;
      check(rf.dbg_data);
      check({16'h0, rf.wr_count});
      write(5'd3, 32'h1234_5678);
      rf.rs1_addr = 5'd3; rf.rs2_addr = 5'd3;
      expect_val("basic_rs1", 32'h1234_5678);
      expect_val("basic_rs2", 32'h1234_5678);
      expect_val("basic_cnt", 32'd1);
      #1;
      check(rf.rs1_data);
      check(rf.rs2_data);
      check({16'h0, rf.wr_count});
      write(5'd0, 32'hFFFF_FFFF);
      rf.rs1_addr = 5'd0; rf.dbg_addr = 5'd0;
      expect_val("x0_rs1", 32'h0);
      expect_val("x0_dbg", 32'h0);
      expect_val("x0_cnt", 32'd1);
      #1;
      check(rf.rs1_data);
      check(rf.dbg_data);
      check({16'h0, rf.wr_count});
      write(5'd31, 32'hA5A5_A5A5);
      write(5'd1, 32'h0000_0001);
      rf.rs1_addr = 5'd31; rf.rs2_addr = 5'd1; rf.dbg_addr = 5'd3;
      expect_val("x31_rs1", 32'hA5A5_A5A5);
      expect_val("x1_rs2", 32'h1);
      expect_val("x3_dbg", 32'h1234_5678);
      expect_val("multi_cnt", 32'd3);
      #1;
      check(rf.rs1_data);
      check(rf.rs2_data);
      check(rf.dbg_data);
      check({16'h0, rf.wr_count});
      write(5'd7, 32'hA);
      @(negedge clk);
      rf.we = 1'b1; rf.rd_addr = 5'd7; rf.rd_data = 32'hB;
      rf.rs1_addr = 5'd3; rf.rs2_addr = 5'd7; rf.dbg_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
      expect_val("coll_rs2", 32'hB);
      expect_val("coll_dbg", 32'hB);
`else
      expect_val("coll_rs2", 32'hA);
      expect_val("coll_dbg", 32'hA);
`endif
      expect_val("coll_rs1_other", 32'h1234_5678);
      #1;
      check(rf.rs2_data);
      check(rf.dbg_data);
      check(rf.rs1_data);
      @(posedge clk);
      #1 rf.we = 1'b0;
      expect_val("coll_after_rs2", 32'hB);
      expect_val("coll_after_cnt", 32'd5);
      #1;
      check(rf.rs2_data);
      check({16'h0, rf.wr_count});
      @(negedge clk);
      rf.we = 1'b1; rf.rd_addr = 5'd0; rf.rd_data = 32'h1111_1111; rf.rs1_addr = 5'd0;
      expect_val("x0_nobypass", 32'h0);
      #1;
      check(rf.rs1_data);
      @(posedge clk);
      #1 rf.we = 1'b0;
      write(5'd9, 32'h55);
      rf.dbg_addr = 5'd9; rf.rs1_addr = 5'd3;
      expect_val("x9_before_rst", 32'h55);
      expect_val("cnt_before_rst", 32'd6);
      #1;
      check(rf.dbg_data);
      check({16'h0, rf.wr_count});
      @(negedge clk);
      #2;
      rf.we = 1'b1; rf.rd_addr = 5'd9; rf.rd_data = 32'h77;
      rst_n = 1'b0;
      expect_val("async_x9", 32'h0);
      expect_val("async_x3", 32'h0);
      expect_val("async_cnt", 32'h0);
      #1;
      check(rf.dbg_data);
      check(rf.rs1_data);
      check({16'h0, rf.wr_count});
      @(posedge clk);
      expect_val("rst_write_lost_x9", 32'h0);
      #1;
      check(rf.dbg_data);
      @(negedge clk);
      rst_n = 1'b1; rf.we = 1'b1; rf.rd_addr = 5'd4; rf.rd_data = 32'hCAFE;
      expect_val("post_rel_x9", 32'h0);
      #1;
      check(rf.dbg_data);
      @(posedge clk);
      #1 rf.we = 1'b0;
      rf.dbg_addr = 5'd4;
      expect_val("first_write_x4", 32'hCAFE);
      expect_val("first_write_cnt", 32'd1);
      #1;
      check(rf.dbg_data);
      check({16'h0, rf.wr_count});
      @(negedge clk);
      rf.we = 1'b1; rf.rd_addr = 5'd1;
      for (int i = 0; i < 65540; i++) begin
         rf.rd_data = i;
         @(negedge clk);
      end
      rf.we = 1'b0;
      rf.rs1_addr = 5'd1;
      expect_val("sat_cnt", 32'h0000_FFFF);
      expect_val("sat_last_data", 32'h0001_0003);
      #1;
      check({16'h0, rf.wr_count});
      check(rf.rs1_data);
      write(5'd2, 32'h2222);
      rf.rs2_addr = 5'd2;
      expect_val("sat_hold_cnt", 32'h0000_FFFF);
      expect_val("sat_hold_x2", 32'h2222);
      #1;
      check({16'h0, rf.wr_count});
      check(rf.rs2_data);
      if (exp_val.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_leftover observed %0d expected 0", exp_val.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
